// File: rtl/mr_ring_sync_if.sv
// Observation/control bundle for the synchronous multirail ring.
// Valid semantics: out_valid is a one-cycle pulse with no ready; it marks the
// cycle in which stage STAGES-1 has just turned from NULL to DATA, and
// out_word/data_cnt are valid alongside it. stall is level-sensitive.
interface mr_ring_sync_if #(
    parameter int RAILS  = 3,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic [RAILS-1:0]  out_word;
    logic              out_valid;
    logic [STAGES-1:0] phase;
    logic [CNT_W-1:0]  data_cnt;

    // Ring side: takes stall, drives observation outputs.
    modport master (
        input  stall,
        output out_word, out_valid, phase, data_cnt
    );

    // Consumer side: drives stall, observes the ring.
    modport slave (
        output stall,
        input  out_word, out_valid, phase, data_cnt
    );
endinterface

// File: rtl/mr_ring_sync.sv
// Cycle-accurate synchronous model of a Muller-pipeline ring carrying one
// DATA/NULL wavefront pair of 1-of-RAILS multirail words. Stage 0 rotates
// the rails of the word it takes from the last stage by ROT positions.
// The phase vector is the ring state exposed for observation.
module mr_ring_sync #(
    parameter int RAILS     = 3,
    parameter int STAGES    = 4,
    parameter int ROT       = 1,
    parameter int INIT_RAIL = 0,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           init,
    mr_ring_sync_if.master bus
);

    localparam logic [RAILS-1:0] RAIL_ONE  = {{(RAILS-1){1'b0}}, 1'b1};
    localparam logic [RAILS-1:0] INIT_WORD = RAIL_ONE << INIT_RAIL;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [RAILS-1:0]  w_q [STAGES];
    logic [RAILS-1:0]  w_d [STAGES];
    logic [STAGES-1:0] p;
    logic [STAGES-1:0] p_d;
    logic [RAILS-1:0]  rot_w;
    logic              rise;
    logic              out_valid_q;
    logic [CNT_W-1:0]  cnt_q;

    // Stage 0 input: output rail j takes input rail (j+ROT) mod RAILS.
    for (genvar j = 0; j < RAILS; j++) begin : g_rot
        assign rot_w[j] = w_q[STAGES-1][(j + ROT) % RAILS];
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int PREV = (i + STAGES - 1) % STAGES;
        localparam int NEXT = (i + 1) % STAGES;

        logic             load;
        logic [RAILS-1:0] src;

        assign p[i]   = |w_q[i];
        // Muller C-element rule: predecessor differs, successor agrees.
        assign load   = (p[PREV] != p[i]) && (p[NEXT] == p[i]);
        assign src    = (i == 0) ? rot_w : w_q[PREV];
        assign w_d[i] = load ? src : w_q[i];
        assign p_d[i] = |w_d[i];

        // Stage register: reset to the initial token, otherwise follow the ring rule unless stalled.
        always_ff @(posedge clk) begin
            if (init) begin
                w_q[i] <= (i == STAGES - 1) ? INIT_WORD : '0;
            end else if (!bus.stall) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // DATA arriving at the last stage on this edge.
    assign rise = p_d[STAGES-1] & ~p[STAGES-1];

    // Arrival pulse and wrapping arrival counter; both frozen by stall.
    always_ff @(posedge clk) begin
        if (init) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else if (bus.stall) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rise;
            if (rise) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.out_word  = w_q[STAGES-1];
    assign bus.out_valid = out_valid_q;
    assign bus.phase     = p;
    assign bus.data_cnt  = cnt_q;

endmodule

// File: tb/tb_mr_ring_sync.sv
// Bench for mr_ring_sync: three parameter sets share clock, init and stall.
// The reference model describes the ring as a two-stage-wide DATA band that
// advances one stage per unstalled edge, with the token rotated once per lap.
module tb_mr_ring_sync;

    logic clk;
    logic init;
    logic stall;

    int n_checks = 0;
    int n_fail   = 0;

    // Parameter sets: A defaults, B 5 stages/4 rails, C no rotation with 4-bit counter.
    int    s_p  [3] = '{4, 5, 4};
    int    r_p  [3] = '{3, 4, 3};
    int    rot_p[3] = '{1, 1, 0};
    int    ir_p [3] = '{0, 0, 0};
    int    cw_p [3] = '{16, 16, 4};
    string tag  [3] = '{"A", "B", "C"};

    mr_ring_sync_if #(.RAILS(3), .STAGES(4), .CNT_W(16)) ifa ();
    mr_ring_sync_if #(.RAILS(4), .STAGES(5), .CNT_W(16)) ifb ();
    mr_ring_sync_if #(.RAILS(3), .STAGES(4), .CNT_W(4))  ifc ();

    assign ifa.stall = stall;
    assign ifb.stall = stall;
    assign ifc.stall = stall;

    mr_ring_sync #(.RAILS(3), .STAGES(4), .ROT(1), .INIT_RAIL(0), .CNT_W(16))
        dut_a (.clk(clk), .init(init), .bus(ifa));
    mr_ring_sync #(.RAILS(4), .STAGES(5), .ROT(1), .INIT_RAIL(0), .CNT_W(16))
        dut_b (.clk(clk), .init(init), .bus(ifb));
    mr_ring_sync #(.RAILS(3), .STAGES(4), .ROT(0), .INIT_RAIL(0), .CNT_W(4))
        dut_c (.clk(clk), .init(init), .bus(ifc));

    logic [31:0] act_ph[3];
    logic [31:0] act_w [3];
    logic [31:0] act_v [3];
    logic [31:0] act_c [3];

    assign act_ph[0] = 32'(ifa.phase);
    assign act_w [0] = 32'(ifa.out_word);
    assign act_v [0] = 32'(ifa.out_valid);
    assign act_c [0] = 32'(ifa.data_cnt);
    assign act_ph[1] = 32'(ifb.phase);
    assign act_w [1] = 32'(ifb.out_word);
    assign act_v [1] = 32'(ifb.out_valid);
    assign act_c [1] = 32'(ifb.data_cnt);
    assign act_ph[2] = 32'(ifc.phase);
    assign act_w [2] = 32'(ifc.out_word);
    assign act_v [2] = 32'(ifc.out_valid);
    assign act_c [2] = 32'(ifc.data_cnt);

    // Per-cycle snapshot {phase, word, valid, cnt} and per-pulse {word, cnt}.
    logic [127:0] exp_q  [3][$];
    logic [63:0]  pulse_q[3][$];

    // Model state: unstalled edges since reset, and whether the last edge advanced.
    int k;
    bit last_act;

    // Clock/reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, a, e);
        end
    endtask

    // After k advancing edges: DATA band occupies stages k-2 and k-1 (k>=1),
    // only the last stage at k=0. The last stage holds DATA when k mod S is 0 or 1,
    // carrying the initial rail moved down by ROT once per completed lap.
    function automatic logic [127:0] model(input int s, input int r, input int rot,
                                           input int ir, input int cw, input int kk,
                                           input bit act);
        logic [31:0] ph, w, v, c;
        int n, rail;
        n  = kk / s;
        ph = '0;
        w  = '0;
        if (kk == 0) ph = 32'd1 << (s - 1);
        else ph = (32'd1 << ((kk - 2 + s) % s)) | (32'd1 << ((kk - 1) % s));
        rail = ((ir - (n * rot) % r) % r + r) % r;
        if (kk == 0 || kk % s == 0 || kk % s == 1) w = 32'd1 << rail;
        v = (act && kk > 0 && kk % s == 0) ? 32'd1 : 32'd0;
        c = (cw >= 32) ? n : (n % (1 << cw));
        return {ph, w, v, c};
    endfunction

    // Driver: apply inputs for one edge, then advance the model and queue expectations.
    task automatic cycle(input bit i_v, input bit s_v);
        logic [127:0] e;
        init  = i_v;
        stall = s_v;
        @(posedge clk);
        if (i_v) begin
            k = 0;
            last_act = 1'b0;
        end else if (s_v) begin
            last_act = 1'b0;
        end else begin
            k++;
            last_act = 1'b1;
        end
        for (int d = 0; d < 3; d++) begin
            e = model(s_p[d], r_p[d], rot_p[d], ir_p[d], cw_p[d], k, last_act);
            exp_q[d].push_back(e);
            if (e[32]) pulse_q[d].push_back({e[95:64], e[31:0]});
        end
        #1;
    endtask

    // Monitor: compares the snapshot every cycle and each out_valid pulse on its own.
    always @(negedge clk) begin
        logic [127:0] e;
        logic [63:0]  pe;
        for (int d = 0; d < 3; d++) begin
            if (exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                chk({tag[d], ".phase"},     act_ph[d], e[127:96]);
                chk({tag[d], ".out_word"},  act_w[d],  e[95:64]);
                chk({tag[d], ".out_valid"}, act_v[d],  e[63:32]);
                chk({tag[d], ".data_cnt"},  act_c[d],  e[31:0]);
            end
            if (act_v[d] === 32'd1) begin
                if (pulse_q[d].size() == 0) begin
                    chk({tag[d], ".unexpected_pulse"}, 32'd1, 32'd0);
                end else begin
                    pe = pulse_q[d].pop_front();
                    chk({tag[d], ".pulse_word"}, act_w[d], pe[63:32]);
                    chk({tag[d], ".pulse_cnt"},  act_c[d], pe[31:0]);
                end
            end
        end
    end

    initial begin
        init  = 1'b1;
        stall = 1'b0;
        k = 0;
        last_act = 1'b0;

        // Reset release and free run through three laps of A.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0);

        // Stall for 5 cycles at k=2.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);

        // Reset mid-run at k=6, then restart.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);

        // Long random-stall run; long enough for C's 4-bit counter to wrap.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 320; i++) cycle(1'b0, $urandom_range(0, 3) == 0);
        stall = 1'b0;

        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk({tag[d], ".pulses_outstanding"}, 32'(pulse_q[d].size()), 32'd0);
            chk({tag[d], ".snapshots_outstanding"}, 32'(exp_q[d].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
